// File: rtl/mycpu_pkg.sv
// Shared types for the mycpu control path: FSM states, opcodes, ALU codes
// and the opcode classification record produced by control_decode.
package mycpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_LDI  = 4'h6,
    OP_LD   = 4'h7,
    OP_ST   = 4'h8,
    OP_JMP  = 4'h9,
    OP_BEQZ = 4'hA,
    OP_HALT = 4'hF
  } opcode_e;

  // ALU operation codes share their values with the ALU opcodes
  localparam logic [3:0] ALU_NONE = 4'h0;
  localparam logic [3:0] ALU_ADD  = 4'h1;
  localparam logic [3:0] ALU_SUB  = 4'h2;
  localparam logic [3:0] ALU_AND  = 4'h3;
  localparam logic [3:0] ALU_OR   = 4'h4;
  localparam logic [3:0] ALU_XOR  = 4'h5;

  typedef struct packed {
    logic alu;
    logic ldi;
    logic ld;
    logic st;
    logic halt;
    logic jmp;
    logic beqz;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode classifier for the control unit.
// MYCPU_BRANCH_EN enables JMP/BEQZ; without it those opcodes classify as illegal.
module control_decode
  import mycpu_pkg::*;
(
  input  logic [3:0] i_opcode,
  output op_class_t  o_cls
);

  always_comb begin
    o_cls = '0;
    case (i_opcode)
      OP_NOP:  ;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: o_cls.alu = 1'b1;
      OP_LDI:  o_cls.ldi  = 1'b1;
      OP_LD:   o_cls.ld   = 1'b1;
      OP_ST:   o_cls.st   = 1'b1;
      OP_HALT: o_cls.halt = 1'b1;
`ifdef MYCPU_BRANCH_EN
      OP_JMP:  o_cls.jmp  = 1'b1;
      OP_BEQZ: o_cls.beqz = 1'b1;
`endif
      default: o_cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit_svamod.sv
// Companion assertions for control_unit: output exclusivity, zeroed unused
// fields, no X on outputs, and all-zero outputs while reset is held.
module control_unit_svamod (
  input logic       clk,
  input logic       rst_n,
  input logic       il,
  input logic       pc_inc,
  input logic       pc_load,
  input logic       mem_rd,
  input logic       mem_wr,
  input logic       mem_sel_pc,
  input logic [3:0] alu_op,
  input logic       rf_we,
  input logic [3:0] rf_waddr,
  input logic       rf_sel_imm,
  input logic       halted,
  input logic       illegal
);

  logic [17:0] w_outs;
  assign w_outs = {il, pc_inc, pc_load, mem_rd, mem_wr, mem_sel_pc, alu_op,
                   rf_we, rf_waddr, rf_sel_imm, halted, illegal};

  a_il_pc_load_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(il && pc_load));

  a_rd_wr_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_rd && mem_wr));

  a_alu_op_unused_zero: assert property (@(posedge clk) disable iff (!rst_n)
    (alu_op != 4'h0) |-> (rf_we && !rf_sel_imm));

  a_waddr_unused_zero: assert property (@(posedge clk) disable iff (!rst_n)
    (rf_waddr != 4'h0) |-> rf_we);

  a_no_x: assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown(w_outs));

  a_reset_zero: assert property (@(posedge clk)
    !rst_n |-> (w_outs == '0));

endmodule

// File: rtl/control_unit.sv
// Multi-cycle CPU control FSM: fetch / decode / execute / memory / halt.
// MYCPU_BRANCH_EN (see control_decode) adds JMP and BEQZ handling in EXEC.
//
// state  | meaning
// IDLE   | one quiet cycle after reset
// FETCH  | read instruction at PC, wait for mem_ready
// DECODE | one cycle, choose EXEC or HALT
// EXEC   | ALU / LDI / branch / NOP, LD and ST continue to MEM
// MEM    | data access at address rs, wait for mem_ready
// HALT   | stopped until reset
module control_unit
  import mycpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ins_in,
  input  logic        mem_ready,
  input  logic        zf,
  output logic        il,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        mem_sel_pc,
  output logic [3:0]  alu_op,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic        rf_sel_imm,
  output logic        halted,
  output logic        illegal
);

  state_e    r_state;
  state_e    w_next;
  op_class_t w_cls;
  logic [3:0] w_rd;
  logic      w_unused_bits;

  assign w_rd          = ins_in[11:8];
  // rs and imm8 are routed straight to the datapath, not used here
  assign w_unused_bits = ^ins_in[7:0];

  control_decode u_decode (
    .i_opcode (ins_in[15:12]),
    .o_cls    (w_cls)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    il         = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_sel_pc = 1'b0;
    alu_op     = ALU_NONE;
    rf_we      = 1'b0;
    rf_waddr   = 4'h0;
    rf_sel_imm = 1'b0;
    halted     = 1'b0;
    illegal    = 1'b0;
    case (r_state)
      ST_IDLE: w_next = ST_FETCH;
      ST_FETCH: begin
        mem_rd     = 1'b1;
        mem_sel_pc = 1'b1;
        if (mem_ready) begin
          il     = 1'b1;
          pc_inc = 1'b1;
          w_next = ST_DECODE;
        end
      end
      ST_DECODE: w_next = w_cls.halt ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        w_next = ST_FETCH;
        if (w_cls.alu) begin
          alu_op   = ins_in[15:12];
          rf_we    = 1'b1;
          rf_waddr = w_rd;
        end
        if (w_cls.ldi) begin
          rf_we      = 1'b1;
          rf_sel_imm = 1'b1;
          rf_waddr   = w_rd;
        end
        if (w_cls.ld || w_cls.st) w_next = ST_MEM;
        if (w_cls.jmp)  pc_load = 1'b1;
        if (w_cls.beqz) pc_load = zf;
        if (w_cls.illegal) illegal = 1'b1;
      end
      ST_MEM: begin
        // opcode no longer a memory op means the access cannot complete; drop it
        if (w_cls.ld) begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            rf_we    = 1'b1;
            rf_waddr = w_rd;
            w_next   = ST_FETCH;
          end
        end else if (w_cls.st) begin
          mem_wr = 1'b1;
          if (mem_ready) w_next = ST_FETCH;
        end else begin
          w_next = ST_FETCH;
        end
      end
      ST_HALT: halted = 1'b1;
      default: w_next = ST_IDLE;
    endcase
  end

  control_unit_svamod u_sva (
    .clk        (clk),
    .rst_n      (rst_n),
    .il         (il),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_sel_pc (mem_sel_pc),
    .alu_op     (alu_op),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_sel_imm (rf_sel_imm),
    .halted     (halted),
    .illegal    (illegal)
  );

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a per-instruction expected-output
// trace is built from the instruction rules and replayed cycle by cycle.
module tb_control_unit;

  typedef struct packed {
    logic       il;
    logic       pc_inc;
    logic       pc_load;
    logic       mem_rd;
    logic       mem_wr;
    logic       mem_sel_pc;
    logic [3:0] alu_op;
    logic       rf_we;
    logic [3:0] rf_waddr;
    logic       rf_sel_imm;
    logic       halted;
    logic       illegal;
  } outs_t;

  typedef struct packed {
    logic        rdy;
    logic [15:0] ins;
    logic        z;
    outs_t       exp;
  } step_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] ins_in = 16'h0;
  logic        mem_ready = 1'b0;
  logic        zf = 1'b0;
  logic        il, pc_inc, pc_load, mem_rd, mem_wr, mem_sel_pc;
  logic [3:0]  alu_op, rf_waddr;
  logic        rf_we, rf_sel_imm, halted, illegal;

  outs_t w_obs;
  step_t q_steps[$];
  int    n_checks = 0;
  int    n_fail = 0;

  assign w_obs = {il, pc_inc, pc_load, mem_rd, mem_wr, mem_sel_pc, alu_op,
                  rf_we, rf_waddr, rf_sel_imm, halted, illegal};

  always #5 clk = ~clk;

  control_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ins_in     (ins_in),
    .mem_ready  (mem_ready),
    .zf         (zf),
    .il         (il),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_sel_pc (mem_sel_pc),
    .alu_op     (alu_op),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_sel_imm (rf_sel_imm),
    .halted     (halted),
    .illegal    (illegal)
  );

  task automatic push(input logic r, input logic [15:0] ins, input logic z, input outs_t e);
    step_t s;
    s.rdy = r; s.ins = ins; s.z = z; s.exp = e;
    q_steps.push_back(s);
  endtask

  // Expected per-cycle outputs for one instruction, starting at its fetch
  task automatic model_instr(input logic [15:0] ins, input logic z, input int fw, input int mw);
    int         op;
    logic [3:0] rd;
    bit         br_en;
    outs_t      e;
    op = int'(ins[15:12]);
    rd = ins[11:8];
`ifdef MYCPU_BRANCH_EN
    br_en = 1'b1;
`else
    br_en = 1'b0;
`endif
    e = '0; e.mem_rd = 1'b1; e.mem_sel_pc = 1'b1;
    for (int i = 0; i < fw; i++) push(1'b0, ins, z, e);
    e.il = 1'b1; e.pc_inc = 1'b1;
    push(1'b1, ins, z, e);
    e = '0;
    push(1'($urandom_range(0, 1)), ins, z, e);
    if (op == 15) begin
      e.halted = 1'b1;
      for (int i = 0; i < 100; i++) push(1'($urandom_range(0, 1)), ins, z, e);
      return;
    end
    if (op >= 1 && op <= 5) begin
      e.alu_op = 4'(op); e.rf_we = 1'b1; e.rf_waddr = rd;
    end else if (op == 6) begin
      e.rf_we = 1'b1; e.rf_sel_imm = 1'b1; e.rf_waddr = rd;
    end else if (op == 9 && br_en) begin
      e.pc_load = 1'b1;
    end else if (op == 10 && br_en) begin
      e.pc_load = z;
    end else if (op >= 9) begin
      e.illegal = 1'b1;
    end
    push(1'($urandom_range(0, 1)), ins, z, e);
    if (op == 7 || op == 8) begin
      for (int i = 0; i <= mw; i++) begin
        e = '0;
        if (op == 7) e.mem_rd = 1'b1;
        else         e.mem_wr = 1'b1;
        if (i == mw && op == 7) begin
          e.rf_we = 1'b1; e.rf_waddr = rd;
        end
        push(i == mw, ins, z, e);
      end
    end
  endtask

  task automatic release_reset(input string nm);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if (w_obs !== outs_t'(0)) begin
      n_fail++;
      $display("FAIL %s idle: got %h expected %h", nm, w_obs, outs_t'(0));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    ins_in = 16'h1230;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if (w_obs !== outs_t'(0)) begin
        n_fail++;
        $display("FAIL reset_hold cyc %0d: got %h expected %h", i, w_obs, outs_t'(0));
      end
    end
    release_reset("reset");
    model_instr(16'h0000, 1'b0, 0, 0);
    for (int i = 0; i < q_steps.size(); i++) begin
      @(negedge clk);
      mem_ready = q_steps[i].rdy; ins_in = q_steps[i].ins; zf = q_steps[i].z;
      #1;
      n_checks++;
      if (w_obs !== q_steps[i].exp) begin
        n_fail++;
        $display("FAIL first_fetch cyc %0d: got %h expected %h", i, w_obs, q_steps[i].exp);
      end
    end
    q_steps.delete();
  endtask

  task automatic test_alu_ldi();
    logic [31:0] r;
    model_instr(16'h1230, 1'b0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      r = $urandom();
      model_instr({4'(k < 8 ? (k % 5) + 1 : 6), r[11:0]}, r[12], int'(r[14:13]), 0);
    end
    for (int i = 0; i < q_steps.size(); i++) begin
      @(negedge clk);
      mem_ready = q_steps[i].rdy; ins_in = q_steps[i].ins; zf = q_steps[i].z;
      #1;
      n_checks++;
      if (w_obs !== q_steps[i].exp) begin
        n_fail++;
        $display("FAIL alu_ldi cyc %0d ins %h: got %h expected %h", i, q_steps[i].ins, w_obs, q_steps[i].exp);
      end
    end
    q_steps.delete();
  endtask

  task automatic test_ld_st();
    model_instr(16'h7150, 1'b0, 1, 3);
    model_instr(16'h8340, 1'b0, 0, 2);
    model_instr(16'h7A00, 1'b1, 2, 0);
    model_instr(16'h8F00, 1'b0, 0, 0);
    for (int i = 0; i < q_steps.size(); i++) begin
      @(negedge clk);
      mem_ready = q_steps[i].rdy; ins_in = q_steps[i].ins; zf = q_steps[i].z;
      #1;
      n_checks++;
      if (w_obs !== q_steps[i].exp) begin
        n_fail++;
        $display("FAIL ld_st cyc %0d ins %h: got %h expected %h", i, q_steps[i].ins, w_obs, q_steps[i].exp);
      end
    end
    q_steps.delete();
  endtask

  task automatic test_branch();
    model_instr(16'hA000, 1'b1, 0, 0);
    model_instr(16'hA000, 1'b0, 0, 0);
    model_instr(16'h9000, 1'b0, 1, 0);
    model_instr(16'hB123, 1'b1, 0, 0);
    model_instr(16'hE000, 1'b0, 0, 0);
    for (int i = 0; i < q_steps.size(); i++) begin
      @(negedge clk);
      mem_ready = q_steps[i].rdy; ins_in = q_steps[i].ins; zf = q_steps[i].z;
      #1;
      n_checks++;
      if (w_obs !== q_steps[i].exp) begin
        n_fail++;
        $display("FAIL branch cyc %0d ins %h: got %h expected %h", i, q_steps[i].ins, w_obs, q_steps[i].exp);
      end
    end
    q_steps.delete();
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int k = 0; k < 40; k++) begin
      r = $urandom();
      model_instr({4'($urandom_range(0, 14)), r[11:0]}, r[12], int'(r[14:13]), int'(r[16:15]));
    end
    for (int i = 0; i < q_steps.size(); i++) begin
      @(negedge clk);
      mem_ready = q_steps[i].rdy; ins_in = q_steps[i].ins; zf = q_steps[i].z;
      #1;
      n_checks++;
      if (w_obs !== q_steps[i].exp) begin
        n_fail++;
        $display("FAIL random cyc %0d ins %h: got %h expected %h", i, q_steps[i].ins, w_obs, q_steps[i].exp);
      end
    end
    q_steps.delete();
  endtask

  // Abort a fetch wait and a MEM wait with an asynchronous reset
  task automatic test_reset_abort();
    int abort_at[2];
    abort_at[0] = 1;
    abort_at[1] = 4;
    for (int a = 0; a < 2; a++) begin
      if (a == 0) model_instr(16'h7150, 1'b0, 3, 3);
      else        model_instr(16'h8250, 1'b0, 0, 3);
      for (int i = 0; i <= abort_at[a]; i++) begin
        @(negedge clk);
        mem_ready = q_steps[i].rdy; ins_in = q_steps[i].ins; zf = q_steps[i].z;
        #1;
        n_checks++;
        if (w_obs !== q_steps[i].exp) begin
          n_fail++;
          $display("FAIL abort%0d pre cyc %0d: got %h expected %h", a, i, w_obs, q_steps[i].exp);
        end
      end
      q_steps.delete();
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (w_obs !== outs_t'(0)) begin
        n_fail++;
        $display("FAIL abort%0d async: got %h expected %h", a, w_obs, outs_t'(0));
      end
      release_reset("abort");
      model_instr(16'h0000, 1'b0, 0, 0);
      for (int i = 0; i < q_steps.size(); i++) begin
        @(negedge clk);
        mem_ready = q_steps[i].rdy; ins_in = q_steps[i].ins; zf = q_steps[i].z;
        #1;
        n_checks++;
        if (w_obs !== q_steps[i].exp) begin
          n_fail++;
          $display("FAIL abort%0d resume cyc %0d: got %h expected %h", a, i, w_obs, q_steps[i].exp);
        end
      end
      q_steps.delete();
    end
  endtask

  task automatic test_halt();
    model_instr(16'hF000, 1'b0, 1, 0);
    for (int i = 0; i < q_steps.size(); i++) begin
      @(negedge clk);
      mem_ready = q_steps[i].rdy; ins_in = q_steps[i].ins; zf = q_steps[i].z;
      #1;
      n_checks++;
      if (w_obs !== q_steps[i].exp) begin
        n_fail++;
        $display("FAIL halt cyc %0d: got %h expected %h", i, w_obs, q_steps[i].exp);
      end
    end
    q_steps.delete();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (w_obs !== outs_t'(0)) begin
      n_fail++;
      $display("FAIL halt_reset: got %h expected %h", w_obs, outs_t'(0));
    end
    release_reset("halt");
    model_instr(16'h6712, 1'b0, 0, 0);
    for (int i = 0; i < q_steps.size(); i++) begin
      @(negedge clk);
      mem_ready = q_steps[i].rdy; ins_in = q_steps[i].ins; zf = q_steps[i].z;
      #1;
      n_checks++;
      if (w_obs !== q_steps[i].exp) begin
        n_fail++;
        $display("FAIL halt_resume cyc %0d: got %h expected %h", i, w_obs, q_steps[i].exp);
      end
    end
    q_steps.delete();
  endtask

  initial begin
    test_reset();
    test_alu_ldi();
    test_ld_st();
    test_branch();
    test_random();
    test_reset_abort();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-003 SHALL have port: ins_in  input  16  current instruction from instruction register output; [15:12] opcode, [11:8] rd, [7:4] rs, [7:0] imm8.
REQ-004 SHALL have port: mem_ready  input  1  memory handshake; access completes in the cycle it is high.
REQ-005 SHALL have port: zf  input  1  ALU zero flag.
REQ-006 SHALL have ports: il  output  1  instruction-register load; pc_inc  output  1; pc_load  output  1.
REQ-007 SHALL have ports: mem_rd  output  1; mem_wr  output  1; mem_sel_pc  output  1  address source (1 = PC, 0 = register rs).
REQ-008 SHALL have ports: alu_op  output  4  ALU operation; rf_we  output  1; rf_waddr  output  4; rf_sel_imm  output  1  (1 = imm8 to register file).
REQ-009 SHALL have ports: halted  output  1; illegal  output  1  one-cycle pulse on an undefined opcode.

Function
REQ-010 SHALL implement the FSM states IDLE, FETCH, DECODE, EXEC, MEM, HALT; outputs SHALL be combinational from the state and ins_in; the state register is the only storage.
REQ-011 IDLE: all outputs 0; SHALL go to FETCH unconditionally the next cycle.
REQ-012 FETCH: mem_rd=1 and mem_sel_pc=1; while mem_ready=0, SHALL stay in FETCH; when mem_ready=1, il=1 and pc_inc=1 in the same cycle, next state DECODE.
REQ-013 DECODE: one cycle, no outputs asserted; on opcode 0xF, next HALT; otherwise next EXEC.
REQ-014 EXEC, opcodes 0x1-0x5 (ADD, SUB, AND, OR, XOR): alu_op = opcode, rf_we=1, rf_waddr=rd, next FETCH.
REQ-015 EXEC, opcode 0x6 (LDI): rf_we=1, rf_sel_imm=1, rf_waddr=rd, next FETCH.
REQ-016 EXEC, opcodes 0x7 (LD) and 0x8 (ST): no outputs asserted, next MEM.
REQ-017 MEM: mem_sel_pc=0; LD drives mem_rd=1 and ST drives mem_wr=1; SHALL stay in MEM while mem_ready=0; on mem_ready=1, LD also asserts rf_we=1 with rf_waddr=rd; next FETCH.
REQ-018 EXEC, opcode 0x0 (NOP): no outputs asserted, next FETCH.
REQ-019 EXEC, undefined opcode: illegal=1 for exactly one cycle, otherwise treated as NOP.
REQ-020 HALT: halted=1 and all other outputs 0; SHALL remain in HALT until reset.
REQ-021 il and pc_load SHALL never be asserted in the same cycle; mem_rd and mem_wr SHALL never be asserted in the same cycle.
REQ-022 Every unused alu_op and rf_waddr value SHALL be driven to 0 (no X on any output).

Reset
REQ-023 rst_n=0 SHALL force state to IDLE asynchronously; all outputs SHALL be 0 while in reset.
REQ-024 Reset asserted in the middle of a FETCH or MEM wait SHALL abandon the access; the first mem_rd after reset SHALL occur 2 cycles after rst_n deasserts.

Configuration
REQ-025 Macro MYCPU_BRANCH_EN defined: opcode 0x9 (JMP) SHALL assert pc_load=1 in EXEC; opcode 0xA (BEQZ) SHALL assert pc_load=zf in EXEC; both go next to FETCH.
REQ-026 Macro MYCPU_BRANCH_EN undefined: opcodes 0x9 and 0xA SHALL be undefined opcodes and handled per REQ-019.

Structure
REQ-027 The state enum, opcode enum and ALU operation encoding SHALL live in mycpu_pkg.
REQ-028 Opcode classification SHALL be a combinational sub-module, control_decode.
REQ-029 A companion assertion module, control_unit_svamod, SHALL check REQ-021, REQ-022 and the reset value.

Verification
REQ-030 Reset, then mem_ready=1 held -> mem_rd=1 in cycle 2; il=1 and pc_inc=1 in that same cycle.
REQ-031 ins_in=0x1230 (ADD r2,r3) -> in EXEC: rf_we=1, rf_waddr=2, alu_op=1; state returns to FETCH.
REQ-032 ins_in=0x7150 (LD r1), mem_ready low for 3 cycles in MEM -> mem_rd held high for 4 cycles; rf_we=1 only in the last of them.
REQ-033 ins_in=0xA000 with zf=1, then zf=0 -> pc_load=1, then pc_load=0 (MYCPU_BRANCH_EN defined); illegal=1 for one cycle (MYCPU_BRANCH_EN undefined).
REQ-034 ins_in=0xF000 -> halted=1 persists for 100 cycles with no mem_rd; rst_n pulse -> back to IDLE, halted=0.
REQ-035 rst_n asserted in the middle of a FETCH wait -> mem_rd=0 immediately (asynchronous); FETCH resumes 2 cycles after release.
